led_blink_scheduler: RTL



---
 rtl/led_pkg.sv | 20 ++
 rtl/led_blink_scheduler_rr_arbiter.sv | 33 +++
 rtl/led_blink_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink scheduler.
// Rate codes match the blink generator's {switch_1, switch_2} selects.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] RATE_100HZ = 2'b00;
    localparam logic [1:0] RATE_50HZ  = 2'b01;
    localparam logic [1:0] RATE_10HZ  = 2'b10;
    localparam logic [1:0] RATE_1HZ   = 2'b11;

    // 1 s display and 100 ms gap at a 25 kHz clock
    localparam int DWELL_DEFAULT = 25000;
    localparam int GAP_DEFAULT   = 2500;

endpackage

// File: rtl/led_blink_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past i_ptr
// and wraps, so the last winner has the lowest priority.
module rr_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % N_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Time-shares the blink LED between status requesters, round-robin,
// with a fixed dwell per grant and an LED-off gap between owners.
//
// state | meaning
// IDLE  | no owner, LED off, waiting for any request
// SHOW  | one owner displayed, dwell counter running
// GAP   | LED off between two different owners
module led_blink_scheduler
    import led_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = DWELL_DEFAULT,
    parameter int GAP_CYCLES   = GAP_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic                 i_clock,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [2*N_REQ-1:0]   i_rate,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_switch_1,
    output logic                 o_switch_2,
    output logic                 o_enable,
    output logic                 o_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam bit HAS_GAP = (GAP_CYCLES != 0);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [1:0]         r_sw, w_sw_nxt;
    logic               r_enable, w_enable_nxt;
    logic               r_busy;

    logic [N_REQ-1:0]   w_win_grant;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;
    logic [1:0]         w_win_rate;
    logic               w_owner_only;
    logic               w_do_arb;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_win_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_win_rate = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win_grant[k]) w_win_rate = i_rate[2*k +: 2];
        end
    end

    // the owner alone keeps the LED without a gap at end of dwell
    assign w_owner_only = ((i_req & r_grant) != '0) && ((i_req & ~r_grant) == '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_sw_nxt     = r_sw;
        w_enable_nxt = r_enable;
        w_do_arb     = 1'b0;

        case (r_state)
            IDLE: w_do_arb = 1'b1;
            SHOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_owner_only || !HAS_GAP) begin
                    w_do_arb = 1'b1;
                end else begin
                    w_state_nxt  = GAP;
                    w_cnt_nxt    = GAP_LOAD;
                    w_grant_nxt  = '0;
                    w_enable_nxt = 1'b0;
                end
            end
            GAP: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                else             w_do_arb  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_do_arb) begin
            if (w_any) begin
                w_state_nxt  = SHOW;
                w_cnt_nxt    = DWELL_LOAD;
                w_ptr_nxt    = w_win_idx;
                w_grant_nxt  = w_win_grant;
                w_sw_nxt     = w_win_rate;
                w_enable_nxt = 1'b1;
            end else begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_grant_nxt  = '0;
                w_enable_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_cnt    <= '0;
            r_grant  <= '0;
            r_sw     <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_sw     <= w_sw_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign o_grant    = r_grant;
    assign o_switch_1 = r_sw[1];
    assign o_switch_2 = r_sw[0];
    assign o_enable   = r_enable;
    assign o_busy     = r_busy;

endmodule
